branch_predictor_bht: RTL and testbench

- Branch history table, downstream of the branch evaluation stage: consumes the resolved branch flag plus the branch PC and trains per-PC 2-bit saturating counters.
- Serves fetch with a registered taken/not-taken prediction for a requested PC.
- Keeps a saturating mispredict counter for performance monitoring.

---
 rtl/branch_predictor_bht.sv | 132 +++++++++++++
 tb/tb_branch_predictor_bht.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_bht.sv
// Per-PC 2-bit BHT with a registered 1-cycle prediction, no back-pressure, and a saturating mispredict counter.
// Defining BHT_GSHARE_EN XORs a global history register into the index.
module branch_predictor_bht #(
  parameter int         IDX_BITS = 6,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ready,
  input  logic        pred_req,
  input  logic [31:0] pred_pc,
  output logic        pred_valid,
  output logic        pred_taken,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_br_flag,
  input  logic        upd_pred_taken,
  output logic [31:0] mispred_cnt
);

  localparam int ENTRIES = 1 << IDX_BITS;

  typedef enum logic {INIT, RUN} state_t;

  state_t              state, state_nx;
  logic [IDX_BITS-1:0] sweep_idx;
  logic [IDX_BITS-1:0] pred_idx, upd_idx;
  logic [1:0]          bht [ENTRIES];
  logic [1:0]          upd_cnt, upd_nx;
  logic                running, do_upd;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[31:IDX_BITS+2], pred_pc[1:0],
                            upd_pc[31:IDX_BITS+2], upd_pc[1:0]};

`ifdef BHT_GSHARE_EN
  logic [IDX_BITS-1:0] ghr;

  assign pred_idx = pred_pc[IDX_BITS+1:2] ^ ghr;
  assign upd_idx  = upd_pc[IDX_BITS+1:2] ^ ghr;

  // Shifts after the table write at the same edge, so that write uses the old history.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr <= '0;
    end else if (do_upd) begin
      ghr <= {ghr[IDX_BITS-2:0], upd_br_flag};
    end
  end
`else
  assign pred_idx = pred_pc[IDX_BITS+1:2];
  assign upd_idx  = upd_pc[IDX_BITS+1:2];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    running  = 1'b0;
    unique case (state)
      INIT: begin
        if (sweep_idx == IDX_BITS'(ENTRIES - 1)) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        running = 1'b1;
      end
      default: state_nx = INIT;
    endcase
  end

  assign ready  = running;
  assign do_upd = running && upd_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      sweep_idx <= '0;
    end else if (!running) begin
      sweep_idx <= sweep_idx + 1'b1;
    end
  end

  always_comb begin
    upd_cnt = bht[upd_idx];
    upd_nx  = upd_cnt;
    if (upd_br_flag) begin
      if (upd_cnt != 2'b11) upd_nx = upd_cnt + 2'd1;
    end else begin
      if (upd_cnt != 2'b00) upd_nx = upd_cnt - 2'd1;
    end
  end

  // The table has no reset of its own; the INIT sweep rewrites every entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!running) begin
        bht[sweep_idx] <= CNT_INIT;
      end else if (upd_valid) begin
        bht[upd_idx] <= upd_nx;
      end
    end
  end

  // Reads the pre-update counter when predict and update hit the same entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
    end else if (running && pred_req) begin
      pred_valid <= 1'b1;
      pred_taken <= bht[pred_idx][1];
    end else begin
      pred_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mispred_cnt <= '0;
    end else if (do_upd && (upd_pred_taken != upd_br_flag) && (mispred_cnt != 32'hFFFF_FFFF)) begin
      mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Random plus directed bench for branch_predictor_bht against a table-of-integers reference model.
module tb_branch_predictor_bht;

  localparam int IDX_BITS = 6;
  localparam int ENTRIES  = 1 << IDX_BITS;

  logic        clk;
  logic        rst;
  logic        ready;
  logic        pred_req;
  logic [31:0] pred_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_br_flag;
  logic        upd_pred_taken;
  logic [31:0] mispred_cnt;

  branch_predictor_bht #(.IDX_BITS(IDX_BITS), .CNT_INIT(2'b01)) dut (
    .clk            (clk),
    .rst            (rst),
    .ready          (ready),
    .pred_req       (pred_req),
    .pred_pc        (pred_pc),
    .pred_valid     (pred_valid),
    .pred_taken     (pred_taken),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_br_flag    (upd_br_flag),
    .upd_pred_taken (upd_pred_taken),
    .mispred_cnt    (mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;
  bit checking = 0;

  // Reference model: counters as plain integers 0..3, ready after ENTRIES released cycles.
  int          m_tab [ENTRIES];
  int          m_cycles;
  bit          m_run;
  bit          m_pv;
  bit          m_pt;
  longint      m_mis;
  int          m_ghr;

  function automatic int idx_of(input logic [31:0] pc, input int ghr);
    int base;
    base = int'((pc >> 2) % ENTRIES);
`ifdef BHT_GSHARE_EN
    return base ^ ghr;
`else
    return base + 0 * ghr;
`endif
  endfunction

  task automatic model_step();
    int pi;
    int ui;
    if (rst) begin
      m_cycles = 0;
      m_run    = 0;
      m_pv     = 0;
      m_pt     = 0;
      m_mis    = 0;
      m_ghr    = 0;
    end else if (!m_run) begin
      m_cycles = m_cycles + 1;
      if (m_cycles == ENTRIES) begin
        m_run = 1;
        for (int i = 0; i < ENTRIES; i++) m_tab[i] = 1;
      end
    end else begin
      pi = idx_of(pred_pc, m_ghr);
      ui = idx_of(upd_pc, m_ghr);
      m_pv = pred_req;
      if (pred_req) m_pt = (m_tab[pi] >= 2);
      if (upd_valid) begin
        if (upd_br_flag) m_tab[ui] = (m_tab[ui] < 3) ? m_tab[ui] + 1 : 3;
        else             m_tab[ui] = (m_tab[ui] > 0) ? m_tab[ui] - 1 : 0;
        if (upd_pred_taken != upd_br_flag && m_mis < 64'hFFFF_FFFF) m_mis = m_mis + 1;
        m_ghr = ((m_ghr << 1) | int'(upd_br_flag)) % ENTRIES;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec = nvec + 1;
    if (act !== exp) begin
      nmis = nmis + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        chk("ready", 32'(ready), 32'(m_run));
        chk("pred_valid", 32'(pred_valid), 32'(m_pv));
        chk("pred_taken", 32'(pred_taken), 32'(m_pt));
        chk("mispred_cnt", mispred_cnt, m_mis[31:0]);
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drv(input bit pr, input logic [31:0] pp, input bit uv,
                     input logic [31:0] up, input bit br, input bit upt);
    pred_req       = pr;
    pred_pc        = pp;
    upd_valid      = uv;
    upd_pc         = up;
    upd_br_flag    = br;
    upd_pred_taken = upt;
    cyc();
  endtask

  initial begin
    rst = 1'b1;
    pred_req = 1'b0; pred_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_br_flag = 1'b0; upd_pred_taken = 1'b0;
    cyc();
    checking = 1;
    cyc();

    // Sweep with requests and mismatching updates held high; all must be ignored.
    rst = 1'b0;
    pred_req = 1'b1; pred_pc = 32'h100;
    upd_valid = 1'b1; upd_pc = 32'h100; upd_br_flag = 1'b1; upd_pred_taken = 1'b0;
    for (int k = 1; k <= ENTRIES; k++) begin
      cyc();
      if (k == ENTRIES - 1) begin
        chk("lit_ready_low_63", 32'(ready), 32'd0);
        chk("lit_pv_in_init", 32'(pred_valid), 32'd0);
      end
      if (k == ENTRIES) chk("lit_ready_high_64", 32'(ready), 32'd1);
    end
    chk("lit_mis_after_init", mispred_cnt, 32'd0);

`ifndef BHT_GSHARE_EN
    drv(1, 32'h100, 0, 0, 0, 0);
    chk("lit_default_pv", 32'(pred_valid), 32'd1);
    chk("lit_default_pt", 32'(pred_taken), 32'd0);
    drv(0, 0, 1, 32'h100, 1, 1);
    drv(0, 0, 1, 32'h100, 1, 1);
    drv(1, 32'h100, 0, 0, 0, 0);
    chk("lit_trained_taken", 32'(pred_taken), 32'd1);
    drv(1, 32'h200, 0, 0, 0, 0);
    chk("lit_alias_0x200", 32'(pred_taken), 32'd1);
    drv(1, 32'h104, 0, 0, 0, 0);
    chk("lit_idx1_0x104", 32'(pred_taken), 32'd0);
    for (int i = 0; i < 3; i++) drv(0, 0, 1, 32'h100, 0, 1);
    drv(1, 32'h100, 0, 0, 0, 0);
    chk("lit_trained_nt", 32'(pred_taken), 32'd0);
    drv(0, 0, 1, 32'h100, 0, 0);
    drv(1, 32'h100, 0, 0, 0, 0);
    chk("lit_sat_low", 32'(pred_taken), 32'd0);
    drv(0, 0, 1, 32'h100, 1, 0);
    drv(1, 32'h100, 1, 32'h100, 1, 0);
    chk("lit_hazard_pre_update", 32'(pred_taken), 32'd0);
    drv(1, 32'h100, 0, 0, 0, 0);
    chk("lit_hazard_post_update", 32'(pred_taken), 32'd1);
    chk("lit_mispred_5", mispred_cnt, 32'd5);
    drv(0, 0, 0, 0, 0, 0);
    chk("lit_idle_pv", 32'(pred_valid), 32'd0);
    chk("lit_idle_pt_hold", 32'(pred_taken), 32'd1);
`endif

    // Random traffic over a small PC window so entries alias and saturate often.
    for (int i = 0; i < 3000; i++) begin
      rst = (i == 1500 || i == 1530) ? 1'b1 : 1'b0;
      drv(1'($urandom), 32'($urandom_range(0, 1023)), 1'($urandom),
          32'($urandom_range(0, 1023)), 1'($urandom), 1'($urandom));
      if (i == 1500) begin
        chk("lit_rst_mis_clear", mispred_cnt, 32'd0);
        chk("lit_rst_ready_low", 32'(ready), 32'd0);
        chk("lit_rst_pv_low", 32'(pred_valid), 32'd0);
      end
    end

    rst = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
